// File: rtl/wave_table_writer_if.sv
// Sample stream from the table loader into wave_table_writer.
interface wave_table_writer_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_last;
    logic                  wr_ready;

    modport master (output wr_valid, wr_data, wr_last, input wr_ready);
    modport slave  (input wr_valid, wr_data, wr_last, output wr_ready);
endinterface

// File: rtl/wave_table_writer.sv
// Loads one waveform bank of a 4-bank sample RAM per transaction; registered read port for playback.
// Optional running checksum of accepted samples: define WAVE_WR_CHECKSUM_EN.
module wave_table_writer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [1:0]            bank_sel,
    input  logic                  abort,
    wave_table_writer_if.slave    wr_if,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [ADDR_WIDTH-2:0] wr_count,
    output logic                  done,
    output logic [3:0]            bank_valid,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] checksum
);
    localparam int unsigned PTR_W      = ADDR_WIDTH - 2;
    localparam int unsigned BANK_DEPTH = 2 ** PTR_W;
    localparam int unsigned MEM_DEPTH  = 4 * BANK_DEPTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [1:0]          bank_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                ready_q;
    logic                start_c;
    logic                accept_c;
    logic [ADDR_WIDTH-1:0] wr_addr_c;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    assign wr_addr_c      = {bank_q, ptr_q};
    assign wr_if.wr_ready = ready_q;

    // Next state; abort wins over a same-cycle accept, bank full forces completion
    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        accept_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    start_c = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (wr_if.wr_valid && ready_q) begin
                    accept_c = 1'b1;
                    if (wr_if.wr_last || (&ptr_q)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered handshake, status and write bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            done       <= 1'b0;
            bank_q     <= '0;
            ptr_q      <= '0;
            addr_out   <= '0;
            wr_count   <= '0;
            bank_valid <= '0;
        end else begin
            ready_q <= (state_d == LOAD);
            done    <= (state_d == DONE);
            if (start_c) begin
                bank_q             <= bank_sel;
                ptr_q              <= '0;
                wr_count           <= '0;
                bank_valid[bank_sel] <= 1'b0;
            end
            if (accept_c) begin
                addr_out <= wr_addr_c;
                ptr_q    <= ptr_q + 1'b1;
                wr_count <= wr_count + 1'b1;
            end
            if ((state_q == LOAD) && (state_d == DONE)) begin
                bank_valid[bank_q] <= 1'b1;
            end
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (accept_c) begin
            mem[wr_addr_c] <= wr_if.wr_data;
        end
    end

    // Read-before-write: a colliding read returns the previous contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

`ifdef WAVE_WR_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_c) begin
            checksum <= '0;
        end else if (accept_c) begin
            checksum <= checksum + wr_if.wr_data;
        end
    end
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_wave_table_writer.sv
// Randomized bench for wave_table_writer against a bank/array reference model.
module tb_wave_table_writer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] bank_sel = 2'd0;
    logic [9:0] rd_addr = 10'd0;
    logic [9:0] addr_out;
    logic [8:0] wr_count;
    logic       done;
    logic [3:0] bank_valid;
    logic [7:0] rd_data;
    logic [7:0] checksum;

    wave_table_writer_if #(.DATA_WIDTH(8)) wr_if ();

    wave_table_writer #(.DATA_WIDTH(8), .ADDR_WIDTH(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bank_sel   (bank_sel),
        .abort      (abort),
        .wr_if      (wr_if),
        .addr_out   (addr_out),
        .wr_count   (wr_count),
        .done       (done),
        .bank_valid (bank_valid),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [7:0] mem_m [1024];
    bit         known [1024];
    logic [3:0] bv_m = 4'd0;
    logic [9:0] last_addr = 10'd0;
    logic [8:0] last_cnt = 9'd0;
    logic [7:0] sum_m = 8'd0;
    logic [7:0] data_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_ck();
`ifdef WAVE_WR_CHECKSUM_EN
        return sum_m;
`else
        return 8'd0;
`endif
    endfunction

    task automatic run_load(input logic [1:0] b, input int n, input bit use_last, input bit do_abort);
        int         acc;
        logic [9:0] a;
        logic [7:0] d;
        logic [7:0] old;
        bit         old_known;
        bit         fin;
        @(negedge clk);
        start    = 1'b1;
        bank_sel = b;
        @(negedge clk);
        start    = 1'b0;
        bank_sel = ~b;
        bv_m[b]  = 1'b0;
        last_cnt = 9'd0;
        sum_m    = 8'd0;
        check("open_ready", 32'(wr_if.wr_ready), 32'd1);
        check("open_bv", 32'(bank_valid), 32'(bv_m));
        check("open_cnt", 32'(wr_count), 32'd0);
        check("open_ck", 32'(checksum), 32'(exp_ck()));
        acc = 0;
        while (acc < n) begin
            if ($urandom_range(0, 3) == 0) begin
                wr_if.wr_valid = 1'b0;
                wr_if.wr_last  = 1'($urandom_range(0, 1));
                wr_if.wr_data  = 8'($urandom);
                start          = 1'($urandom_range(0, 1));
                bank_sel       = 2'($urandom);
                @(negedge clk);
                start         = 1'b0;
                wr_if.wr_last = 1'b0;
                check("gap_ready", 32'(wr_if.wr_ready), 32'd1);
                check("gap_done", 32'(done), 32'd0);
                check("gap_cnt", 32'(wr_count), 32'(last_cnt));
            end else begin
                a = {b, 8'(acc)};
                if (data_q.size() > 0) d = data_q.pop_front();
                else d = 8'($urandom);
                old       = mem_m[a];
                old_known = known[a];
                wr_if.wr_valid = 1'b1;
                wr_if.wr_data  = d;
                wr_if.wr_last  = use_last && (acc == n - 1);
                rd_addr        = a;
                start          = ($urandom_range(0, 7) == 0);
                bank_sel       = 2'($urandom);
                @(negedge clk);
                fin = wr_if.wr_last || (acc == 255);
                wr_if.wr_valid = 1'b0;
                wr_if.wr_last  = 1'b0;
                start          = 1'b0;
                mem_m[a]  = d;
                known[a]  = 1'b1;
                acc++;
                sum_m     = sum_m + d;
                last_addr = a;
                last_cnt  = 9'(acc);
                check("wr_addr", 32'(addr_out), 32'(a));
                check("wr_cnt", 32'(wr_count), 32'(last_cnt));
                if (old_known) check("rd_old", 32'(rd_data), 32'(old));
                if (fin) begin
                    bv_m[b] = 1'b1;
                    check("done_pulse", 32'(done), 32'd1);
                    check("done_ready", 32'(wr_if.wr_ready), 32'd0);
                    check("done_bv", 32'(bank_valid), 32'(bv_m));
                    check("done_ck", 32'(checksum), 32'(exp_ck()));
                    start    = 1'b1;
                    bank_sel = 2'($urandom);
                    @(negedge clk);
                    start = 1'b0;
                    check("post_done", 32'(done), 32'd0);
                    check("post_ready", 32'(wr_if.wr_ready), 32'd0);
                    check("post_bv", 32'(bank_valid), 32'(bv_m));
                    return;
                end
                check("load_done", 32'(done), 32'd0);
                check("load_ready", 32'(wr_if.wr_ready), 32'd1);
            end
        end
        if (do_abort) begin
            a = {b, 8'(acc)};
            abort          = 1'b1;
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 8'($urandom);
            rd_addr        = a;
            @(negedge clk);
            abort          = 1'b0;
            wr_if.wr_valid = 1'b0;
            check("abort_ready", 32'(wr_if.wr_ready), 32'd0);
            check("abort_done", 32'(done), 32'd0);
            check("abort_bv", 32'(bank_valid), 32'(bv_m));
            check("abort_cnt", 32'(wr_count), 32'(last_cnt));
            check("abort_addr", 32'(addr_out), 32'(last_addr));
            check("abort_ck", 32'(checksum), 32'(exp_ck()));
            @(negedge clk);
            check("abort_nodone", 32'(done), 32'd0);
            if (known[a]) check("abort_nowrite", 32'(rd_data), 32'(mem_m[a]));
        end
    endtask

    task automatic idle_valid(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 8'($urandom);
            wr_if.wr_last  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("idle_ready", 32'(wr_if.wr_ready), 32'd0);
            check("idle_addr", 32'(addr_out), 32'(last_addr));
            check("idle_cnt", 32'(wr_count), 32'(last_cnt));
            check("idle_done", 32'(done), 32'd0);
        end
        wr_if.wr_valid = 1'b0;
        wr_if.wr_last  = 1'b0;
    endtask

    task automatic reset_mid_load(input logic [1:0] b);
        logic [9:0] a;
        @(negedge clk);
        start    = 1'b1;
        bank_sel = b;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = {b, 8'(i)};
            wr_if.wr_valid = 1'b1;
            wr_if.wr_data  = 8'($urandom);
            mem_m[a] = wr_if.wr_data;
            known[a] = 1'b1;
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        bv_m = 4'd0; last_addr = 10'd0; last_cnt = 9'd0; sum_m = 8'd0;
        check("rst_mid_ready", 32'(wr_if.wr_ready), 32'd0);
        check("rst_mid_bv", 32'(bank_valid), 32'd0);
        check("rst_mid_addr", 32'(addr_out), 32'd0);
        check("rst_mid_cnt", 32'(wr_count), 32'd0);
        check("rst_mid_ck", 32'(checksum), 32'd0);
        check("rst_mid_rd", 32'(rd_data), 32'd0);
        @(negedge clk);
        wr_if.wr_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(wr_if.wr_ready), 32'd0);
    endtask

    task automatic readback(input int n);
        logic [9:0] a;
        for (int i = 0; i < n; i++) begin
            a = 10'($urandom);
            for (int t = 0; t < 32 && !known[a]; t++) a = 10'($urandom);
            if (known[a]) begin
                rd_addr = a;
                @(negedge clk);
                check("readback", 32'(rd_data), 32'(mem_m[a]));
            end
        end
    endtask

    initial begin
        logic [1:0] rb;
        int         rn;
        bit         ra;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'd0;
        wr_if.wr_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(wr_if.wr_ready), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bv", 32'(bank_valid), 32'd0);
        check("rst_addr", 32'(addr_out), 32'd0);
        check("rst_cnt", 32'(wr_count), 32'd0);
        check("rst_rd", 32'(rd_data), 32'd0);
        check("rst_ck", 32'(checksum), 32'd0);
        rst_n = 1'b1;

        data_q.push_back(8'hFF);
        data_q.push_back(8'h02);
        run_load(2'd3, 2, 1'b1, 1'b0);
`ifdef WAVE_WR_CHECKSUM_EN
        check("ck_ff02", 32'(checksum), 32'h01);
`else
        check("ck_ff02", 32'(checksum), 32'h00);
`endif

        data_q.push_back(8'h11);
        data_q.push_back(8'h22);
        data_q.push_back(8'h33);
        run_load(2'd2, 3, 1'b1, 1'b0);
        check("b2_cnt", 32'(wr_count), 32'd3);
        check("b2_valid", 32'(bank_valid[2]), 32'd1);
        check("b2_addr", 32'(addr_out), 32'h202);
        rd_addr = 10'h201;
        @(negedge clk);
        check("rd_201", 32'(rd_data), 32'h22);

        run_load(2'd1, 256, 1'b0, 1'b0);
        run_load(2'd0, 256, 1'b0, 1'b0);
        check("full_cnt", 32'(wr_count), 32'd256);
        check("full_addr", 32'(addr_out), 32'h0FF);
        rd_addr = 10'h100;
        @(negedge clk);
        check("rd_100_kept", 32'(rd_data), 32'(mem_m[10'h100]));

        run_load(2'd1, 5, 1'b0, 1'b1);
        check("abort_b1", 32'(bank_valid[1]), 32'd0);
        check("abort_cnt5", 32'(wr_count), 32'd5);

        idle_valid(4);
        reset_mid_load(2'd2);

        repeat (6) begin
            rb = 2'($urandom);
            rn = $urandom_range(1, 40);
            ra = ($urandom_range(0, 3) == 0);
            run_load(rb, rn, !ra, ra);
            idle_valid(2);
        end
        readback(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
